pc_unit: RTL and testbench

Parametrised RISC-V program counter for the single-cycle/fetch datapath: holds the current instruction address and selects the next one from sequential increment, conditional branch, JAL or JALR. Adds stall, redirect-flush signalling and optional misaligned-target trapping. Sits between the decoder/ALU (target and condition sources) and instruction memory (`pcOut` drives the fetch address).

---
 rtl/pc_unit_if.sv | 46 ++++
 rtl/pc_unit.sv | 140 ++++++++++++++
 tb/tb_pc_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if -- signal bundle between the fetch-stage control (decoder/ALU side)
// and the program counter unit.
//
// Signals (pc_unit is the slave, the control side is the master):
//   incr      master->slave  advance enable
//   stall     master->slave  pipeline stall, overrides incr and redirects
//   pcSel     master->slave  next-PC source: 00 seq, 01 branch, 10 jal, 11 jalr
//   brTaken   master->slave  branch condition, looked at only when pcSel = 01
//   imm       master->slave  sign-extended immediate offset
//   rs1       master->slave  JALR base register value
//   trapAck   master->slave  releases the TRAP state
//   pcOut     slave->master  current fetch address (registered)
//   pcLink    slave->master  pcOut + STEP (combinational)
//   flush     slave->master  one-cycle pulse after a committed taken redirect
//   trap      slave->master  high while in TRAP
//   dbg_state slave->master  FSM state for observation: 0 RUN, 1 REDIR, 2 TRAP
//
// Handshake: there is no valid/ready pairing here. Every input is a level that
// the PC samples on each rising clock edge; every output is valid in every
// cycle outside reset and reflects the state after the most recent edge.
interface pc_unit_if #(
  parameter int ALEN = 32
);
  logic            incr;
  logic            stall;
  logic [1:0]      pcSel;
  logic            brTaken;
  logic [ALEN-1:0] imm;
  logic [ALEN-1:0] rs1;
  logic            trapAck;
  logic [ALEN-1:0] pcOut;
  logic [ALEN-1:0] pcLink;
  logic            flush;
  logic            trap;
  logic [1:0]      dbg_state;

  modport master (
    output incr, stall, pcSel, brTaken, imm, rs1, trapAck,
    input  pcOut, pcLink, flush, trap, dbg_state
  );

  modport slave (
    input  incr, stall, pcSel, brTaken, imm, rs1, trapAck,
    output pcOut, pcLink, flush, trap, dbg_state
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit -- RISC-V program counter for the fetch datapath.
//
// Holds the current instruction address and picks the next one from the
// sequential increment, a conditional branch, JAL or JALR. Signals a one-cycle
// flush after every committed taken redirect and, optionally, traps on a
// misaligned redirect target.
//
// Parameters:
//   ALEN      address width in bits (>= 8)
//   STEP      sequential increment in bytes (power of two)
//   RESET_VEC pcOut value on reset
//   TRAP_VEC  pcOut value on a misaligned-target trap
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    pc_unit_if.slave bundle (see rtl/pc_unit_if.sv)
//
// Optional feature macro: PC_TRAP_EN
//   defined   -> a taken target with bit 1 set (STEP = 4) loads TRAP_VEC and
//                enters TRAP until trapAck; no flush is raised for it.
//   undefined -> redirect targets have bits [1:0] forced to 0, trap is tied
//                low and trapAck is ignored.
module pc_unit #(
  parameter int              ALEN      = 32,
  parameter int              STEP      = 4,
  parameter logic [ALEN-1:0] RESET_VEC = '0,
  parameter logic [ALEN-1:0] TRAP_VEC  = ALEN'('h100)
) (
  input logic      clock,
  input logic      reset,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [ALEN-1:0] STEP_W = ALEN'(STEP);

  state_t          r_state;
  logic [ALEN-1:0] r_pc;
  logic            r_flush;

  logic [ALEN-1:0] w_seq;
  logic [ALEN-1:0] w_brj;
  logic [ALEN-1:0] w_jalr;
  logic [ALEN-1:0] w_tgt_raw;
  logic [ALEN-1:0] w_tgt;
  logic [ALEN-1:0] w_next;
  logic            w_taken;
  logic            w_misal;
  logic            w_update;

  // All target arithmetic wraps modulo 2^ALEN; carries are simply dropped.
  assign w_seq  = r_pc + STEP_W;
  assign w_brj  = r_pc + bus.imm;
  assign w_jalr = (bus.rs1 + bus.imm) & ~ALEN'(1);

  always_comb begin
    w_taken   = 1'b0;
    w_tgt_raw = w_brj;
    case (bus.pcSel)
      2'b01:   w_taken = bus.brTaken;
      2'b10:   w_taken = 1'b1;
      2'b11: begin
        w_taken   = 1'b1;
        w_tgt_raw = w_jalr;
      end
      default: w_taken = 1'b0;
    endcase
  end

`ifdef PC_TRAP_EN
  logic r_trap;

  assign w_tgt   = w_tgt_raw;
  // Only a 4-byte instruction stream can be half-word misaligned.
  assign w_misal = w_taken && (STEP == 4) && w_tgt_raw[1];
  assign bus.trap = r_trap;
`else
  wire w_unused_trap_ack = bus.trapAck;

  assign w_tgt   = {w_tgt_raw[ALEN-1:2], 2'b00};
  assign w_misal = 1'b0;
  assign bus.trap = 1'b0;
`endif

  assign w_next   = w_taken ? w_tgt : w_seq;
  // stall outranks incr; the TRAP hold outranks both and is handled below.
  assign w_update = bus.incr && !bus.stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_VEC;
      r_flush <= 1'b0;
`ifdef PC_TRAP_EN
      r_trap  <= 1'b0;
`endif
    end else begin
      // flush is a single-cycle pulse unless a new taken redirect re-arms it.
      r_flush <= 1'b0;
      if (r_state == S_TRAP) begin
`ifdef PC_TRAP_EN
        // pcOut stays at TRAP_VEC across the release; updates resume after.
        if (bus.trapAck) begin
          r_state <= S_RUN;
          r_trap  <= 1'b0;
        end
`else
        r_state <= S_RUN;
`endif
      end else if (w_update) begin
        if (w_misal) begin
          r_pc    <= TRAP_VEC;
          r_state <= S_TRAP;
`ifdef PC_TRAP_EN
          r_trap  <= 1'b1;
`endif
        end else begin
          r_pc    <= w_next;
          r_state <= w_taken ? S_REDIR : S_RUN;
          r_flush <= w_taken;
        end
      end else begin
        // Holding the PC also drops a pending REDIR back to RUN.
        r_state <= S_RUN;
      end
    end
  end

  assign bus.pcOut     = r_pc;
  assign bus.pcLink    = r_pc + STEP_W;
  assign bus.flush     = r_flush;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- self-checking bench for pc_unit (ALEN 32, STEP 4, RESET_VEC 0,
// TRAP_VEC 0x100). Expectations for both builds: with and without PC_TRAP_EN.
module tb_pc_unit;
  localparam int ALEN = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_unit_if #(.ALEN(ALEN)) bus ();

  pc_unit #(
    .ALEN     (32),
    .STEP     (4),
    .RESET_VEC(32'h0),
    .TRAP_VEC (32'h100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the architectural PC, whether we sit in a trap, and the flush pulse.
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_trap;

  task automatic model_step();
    logic [31:0] tgt;
    bit          redirect;
    if (m_trap) begin
      m_flush = 1'b0;
`ifdef PC_TRAP_EN
      if (bus.trapAck) m_trap = 1'b0;
`endif
      return;
    end
    if (bus.stall || !bus.incr) begin
      m_flush = 1'b0;
      return;
    end
    redirect = (bus.pcSel == 2'd2) || (bus.pcSel == 2'd3) ||
               (bus.pcSel == 2'd1 && bus.brTaken);
    if (!redirect) begin
      m_pc    = m_pc + 32'd4;
      m_flush = 1'b0;
      return;
    end
    if (bus.pcSel == 2'd3) tgt = (bus.rs1 + bus.imm) & 32'hFFFF_FFFE;
    else                   tgt = m_pc + bus.imm;
`ifdef PC_TRAP_EN
    if (tgt[1]) begin
      m_pc    = 32'h100;
      m_trap  = 1'b1;
      m_flush = 1'b0;
      return;
    end
    m_pc = tgt;
`else
    m_pc = tgt & 32'hFFFF_FFFC;
`endif
    m_flush = 1'b1;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc    = 32'h0;
      m_flush = 1'b0;
      m_trap  = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (cmp_en && reset) begin
      chk("cyc_pc",    bus.pcOut,  m_pc);
      chk("cyc_link",  bus.pcLink, m_pc + 32'd4);
      chk("cyc_flush", {31'b0, bus.flush}, {31'b0, m_flush});
      chk("cyc_trap",  {31'b0, bus.trap},  {31'b0, m_trap});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit inc, input bit stl, input logic [1:0] sel,
                       input bit br, input logic [31:0] im, input logic [31:0] r1,
                       input bit ack);
    bus.incr    = inc;
    bus.stall   = stl;
    bus.pcSel   = sel;
    bus.brTaken = br;
    bus.imm     = im;
    bus.rs1     = r1;
    bus.trapAck = ack;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input bit fl, input bit tr);
    chk({tag, "_pc"},    bus.pcOut, pc);
    chk({tag, "_flush"}, {31'b0, bus.flush}, {31'b0, fl});
    chk({tag, "_trap"},  {31'b0, bus.trap},  {31'b0, tr});
  endtask

  // Assert reset away from any clock edge, check it took effect without an
  // edge, hold it across one rising edge, then release after a falling edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    expect_out({tag, "_async"}, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    expect_out({tag, "_held"}, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.incr = 1'b0; bus.stall = 1'b0; bus.pcSel = 2'd0; bus.brTaken = 1'b0;
    bus.imm = 32'h0; bus.rs1 = 32'h0; bus.trapAck = 1'b0;

    #2 reset = 1'b0;
    #1;
    expect_out("rst", 32'h0, 1'b0, 1'b0);
    chk("rst_link", bus.pcLink, 32'h4);
    @(negedge clock);
    #1;
    reset  = 1'b1;
    cmp_en = 1'b1;
    expect_out("rel", 32'h0, 1'b0, 1'b0);

    // sequential fetch
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 0); expect_out("seq1", 32'h4, 0, 0);
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 0); expect_out("seq2", 32'h8, 0, 0);
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 0); expect_out("seq3", 32'hC, 0, 0);
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 0); expect_out("seq4", 32'h10, 0, 0);

    // branch not taken, jal back, branch taken (back-to-back redirects)
    drive(1, 0, 2'd1, 0, 32'hFFFF_FFF8, 32'h0, 0); expect_out("br_nt", 32'h14, 0, 0);
    drive(1, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 0); expect_out("jal_back", 32'h10, 1, 0);
    drive(1, 0, 2'd1, 1, 32'hFFFF_FFF8, 32'h0, 0); expect_out("br_t", 32'h8, 1, 0);
    // incr low holds, flush drops
    drive(0, 0, 2'd2, 1, 32'h40, 32'h0, 0);        expect_out("hold", 32'h8, 0, 0);

    // jal to 0x20, then stalled jalr (REDIR must not extend flush), then jalr
    drive(1, 0, 2'd2, 0, 32'h18, 32'h0, 0);        expect_out("jal20", 32'h20, 1, 0);
    drive(1, 1, 2'd3, 0, 32'h4, 32'h101, 0);       expect_out("stall", 32'h20, 0, 0);
    drive(1, 0, 2'd3, 0, 32'h4, 32'h101, 0);       expect_out("jalr", 32'h104, 1, 0);
    chk("jalr_link", bus.pcLink, 32'h108);

    // wrap at top of address space
    drive(1, 0, 2'd3, 0, 32'h0, 32'hFFFF_FFFC, 0); expect_out("jalr_top", 32'hFFFF_FFFC, 1, 0);
    chk("top_link", bus.pcLink, 32'h0);
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 0);         expect_out("wrap", 32'h0, 0, 0);

    // reset in the middle of a redirect
    drive(1, 0, 2'd2, 0, 32'h44, 32'h0, 0);        expect_out("jal44", 32'h44, 1, 0);
    async_reset("rst_redir");

    // misaligned jal target
    drive(1, 0, 2'd2, 0, 32'h40, 32'h0, 0);        expect_out("jal40", 32'h40, 1, 0);
    drive(1, 0, 2'd2, 0, 32'h2, 32'h0, 0);
`ifdef PC_TRAP_EN
    expect_out("mis", 32'h100, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2'd2, 0, 32'h8, 32'h0, 0);
      expect_out("trap_hold", 32'h100, 0, 1);
    end
    drive(1, 0, 2'd2, 0, 32'h8, 32'h0, 1);         expect_out("ack", 32'h100, 0, 0);
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 0);         expect_out("post_ack", 32'h104, 0, 0);
    drive(1, 0, 2'd2, 0, 32'h2, 32'h0, 0);         expect_out("mis2", 32'h100, 0, 1);
    async_reset("rst_trap");
`else
    expect_out("mis", 32'h40, 1, 0);
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 1);         expect_out("ack_ign", 32'h44, 0, 0);
`endif

    // pseudo-random mix, checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            (32'($urandom_range(0, 31)) << 1) - 32'd32,
            32'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) == 0));
    end

    @(negedge clock);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
